// File: rtl/arb_mem_rr.sv
// rtl/arb_mem_rr.sv - round-robin arbiter sequencing N_REQ requesters onto one single-port memory
// Define ARB_LOCK_EN to add the lock port and bounded burst-lock re-grant.
module arb_mem_rr #(
  parameter int N_REQ    = 4,
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MAX_LOCK = 4
) (
  input  logic                clk,
  input  logic                reset_L,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    we,
  input  logic [N_REQ*AW-1:0] addr,
  input  logic [N_REQ*DW-1:0] wdata,
  output logic [N_REQ-1:0]    ack,
  output logic [DW-1:0]       rdata,
  output logic [N_REQ-1:0]    gnt,
  output logic                busy,
  output logic                mem_en,
  output logic                mem_we,
  output logic [AW-1:0]       mem_addr,
  output logic [DW-1:0]       mem_wdata,
  input  logic [DW-1:0]       mem_rdata
`ifdef ARB_LOCK_EN
  ,
  input  logic [N_REQ-1:0]    lock
`endif
);

  localparam int LW = $clog2(N_REQ);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_ACK    = 2'd3;

  logic [1:0]    r_state;
  logic [LW-1:0] r_last;
  logic          r_wr;
  logic [LW-1:0] w_rr;
  logic [LW-1:0] w_sel;
  logic [LW-1:0] w_cand;
  logic          w_any;
  int            w_idx;

  // Scan from the farthest offset down so the nearest set bit after r_last wins.
  always_comb begin
    w_rr   = r_last;
    w_any  = 1'b0;
    w_idx  = 0;
    w_cand = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_idx = int'(r_last) + k;
      if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
      w_cand = LW'(w_idx);
      if (req[w_cand]) begin
        w_rr  = w_cand;
        w_any = 1'b1;
      end
    end
  end

`ifdef ARB_LOCK_EN
  localparam int LCW = $clog2(MAX_LOCK) + 1;

  logic [LCW-1:0] r_lock_cnt;
  logic           w_lock_hit;

  assign w_lock_hit = req[r_last] && lock[r_last] && (r_lock_cnt < LCW'(MAX_LOCK - 1));
  assign w_sel      = w_lock_hit ? r_last : w_rr;

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_lock_cnt <= '0;
    end else if (r_state == S_IDLE && w_any) begin
      r_lock_cnt <= w_lock_hit ? r_lock_cnt + LCW'(1) : '0;
    end
  end
`else
  assign w_sel = w_rr;
`endif

  assign busy = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_state   <= S_IDLE;
      r_last    <= LW'(N_REQ - 1);
      r_wr      <= 1'b0;
      gnt       <= '0;
      ack       <= '0;
      rdata     <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            gnt         <= '0;
            gnt[w_sel]  <= 1'b1;
            mem_en      <= 1'b1;
            mem_we      <= we[w_sel];
            mem_addr    <= addr[int'(w_sel)*AW +: AW];
            mem_wdata   <= wdata[int'(w_sel)*DW +: DW];
            r_wr        <= we[w_sel];
            r_last      <= w_sel;
            r_state     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          mem_en  <= 1'b0;
          mem_we  <= 1'b0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // gnt already holds the winner one-hot, so it doubles as the ack pattern
          rdata   <= r_wr ? '0 : mem_rdata;
          ack     <= gnt;
          r_state <= S_ACK;
        end
        default: begin
          ack       <= '0;
          gnt       <= '0;
          rdata     <= '0;
          mem_addr  <= '0;
          mem_wdata <= '0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arb_mem_rr.sv
// tb/tb_arb_mem_rr.sv - directed self-checking bench for arb_mem_rr
module tb_arb_mem_rr;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            reset_L;
  logic [N-1:0]    req;
  logic [N-1:0]    we;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    ack;
  logic [DW-1:0]   rdata;
  logic [N-1:0]    gnt;
  logic            busy;
  logic            mem_en;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata = '0;
`ifdef ARB_LOCK_EN
  logic [N-1:0]    lock;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  arb_mem_rr #(.N_REQ(N), .AW(AW), .DW(DW), .MAX_LOCK(4)) dut (
    .clk       (clk),
    .reset_L   (reset_L),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .ack       (ack),
    .rdata     (rdata),
    .gnt       (gnt),
    .busy      (busy),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef ARB_LOCK_EN
    ,
    .lock      (lock)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: returns addr ^ 8'hB7 one cycle after any strobe, 0 otherwise.
  always @(posedge clk) mem_rdata <= mem_en ? (mem_addr ^ 8'hB7) : 8'h00;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  initial begin
    logic [N-1:0]  oh;
    logic [DW-1:0] exp_rd;
    int            e;
`ifdef ARB_LOCK_EN
    int lock_seq [6] = '{0, 0, 0, 0, 1, 0};
    lock = '0;
`endif
    req = '0; we = '0; addr = '0; wdata = '0; reset_L = 1'b0;
    tick(); tick();
    check("rst_gnt",   32'(gnt), 32'h0);
    check("rst_ack",   32'(ack), 32'h0);
    check("rst_en",    32'(mem_en), 32'h0);
    check("rst_busy",  32'(busy), 32'h0);
    check("rst_rdata", 32'(rdata), 32'h0);
    reset_L = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_gnt",  32'(gnt), 32'h0);
      check("idle_ack",  32'(ack), 32'h0);
      check("idle_en",   32'(mem_en), 32'h0);
      check("idle_busy", 32'(busy), 32'h0);
    end

    // single read; req dropped right after the grant must not abort it
    addr[0 +: AW] = 8'h12; we = '0; req = 4'b0001;
    tick();
    check("rd_en",   32'(mem_en), 32'h1);
    check("rd_we",   32'(mem_we), 32'h0);
    check("rd_addr", 32'(mem_addr), 32'h12);
    check("rd_gnt",  32'(gnt), 32'h1);
    check("rd_busy", 32'(busy), 32'h1);
    req = '0;
    tick();
    check("rd_en_off", 32'(mem_en), 32'h0);
    check("rd_ack_early", 32'(ack), 32'h0);
    tick();
    check("rd_ack",   32'(ack), 32'h1);
    check("rd_rdata", 32'(rdata), 32'hA5);
    tick();
    check("rd_ack_clr",   32'(ack), 32'h0);
    check("rd_gnt_clr",   32'(gnt), 32'h0);
    check("rd_rdata_clr", 32'(rdata), 32'h0);
    check("rd_busy_clr",  32'(busy), 32'h0);

    // single write
    addr[2*AW +: AW] = 8'h30; wdata[2*DW +: DW] = 8'h5C; we = 4'b0100; req = 4'b0100;
    tick();
    check("wr_en",    32'(mem_en), 32'h1);
    check("wr_we",    32'(mem_we), 32'h1);
    check("wr_addr",  32'(mem_addr), 32'h30);
    check("wr_wdata", 32'(mem_wdata), 32'h5C);
    check("wr_gnt",   32'(gnt), 32'h4);
    tick();
    check("wr_en_off", 32'(mem_en), 32'h0);
    check("wr_we_off", 32'(mem_we), 32'h0);
    tick();
    check("wr_ack",   32'(ack), 32'h4);
    check("wr_rdata", 32'(rdata), 32'h0);
    req = '0; we = '0;
    tick();
    check("wr_idle", 32'(busy), 32'h0);

    // full contention held from reset: order 0,1,2,3,0
    addr = {8'h43, 8'h42, 8'h41, 8'h40};
    req = 4'b1111; reset_L = 1'b0;
    tick();
    reset_L = 1'b1;
    for (int t = 0; t < 5; t++) begin
      e = t % N;
      oh = 4'b0001 << e;
      exp_rd = (8'h40 + 8'(e)) ^ 8'hB7;
      tick();
      check("ct_gnt",  32'(gnt), 32'(oh));
      check("ct_addr", 32'(mem_addr), 32'(8'h40 + 8'(e)));
      tick(); tick();
      check("ct_ack",   32'(ack), 32'(oh));
      check("ct_rdata", 32'(rdata), 32'(exp_rd));
      tick();
      check("ct_idle_busy", 32'(busy), 32'h0);
      check("ct_idle_gnt",  32'(gnt), 32'h0);
    end

    // reset during WAIT drops the transaction and restores the rotation pointer
    req = 4'b0010;
    tick();
    check("mr_gnt1", 32'(gnt), 32'h2);
    tick();
    reset_L = 1'b0;
    tick();
    check("mr_gnt",  32'(gnt), 32'h0);
    check("mr_ack",  32'(ack), 32'h0);
    check("mr_en",   32'(mem_en), 32'h0);
    check("mr_busy", 32'(busy), 32'h0);
    check("mr_addr", 32'(mem_addr), 32'h0);
    reset_L = 1'b1; req = 4'b0110;
    tick();
    check("mr_no_ack", 32'(ack), 32'h0);
    check("mr_regnt",  32'(gnt), 32'h2);
    tick(); tick();
    check("mr_ack2",  32'(ack), 32'h2);
    check("mr_rdata", 32'(rdata), 32'(8'h41 ^ 8'hB7));
    req = '0;
    tick();

`ifdef ARB_LOCK_EN
    req = 4'b0011; lock = 4'b0001; reset_L = 1'b0;
    tick();
    reset_L = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("lk_gnt", 32'(gnt), 32'(4'b0001 << lock_seq[i]));
      tick(); tick(); tick();
    end
    req = '0; lock = '0;
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/arb_mem_rr.md
Name: arb_mem_rr

Overview:
Round-robin arbiter and sequencer that shares one single-port synchronous memory among N_REQ requesters. It accepts level requests, picks one winner per transaction, and drives the memory port with registered signals. It returns read data and a one-cycle ack to the winner. It sits between the requesting datapath blocks and the memory array.

Parameters:
N_REQ, 4, number of requesters (legal range 2..8)
AW, 8, memory address width
DW, 8, memory data width
MAX_LOCK, 4, maximum consecutive locked transactions (used only with ARB_LOCK_EN)

Ports:
clk  in  1  single clock; all logic samples on its rising edge
reset_L  in  1  synchronous reset, active-low
req  in  N_REQ  level request, one bit per requester
we  in  N_REQ  write enable per requester (1 = write, 0 = read)
addr  in  N_REQ*AW  flattened addresses; requester i uses bits [i*AW +: AW]
wdata  in  N_REQ*DW  flattened write data; requester i uses bits [i*DW +: DW]
ack  out  N_REQ  one-hot, one-cycle completion pulse
rdata  out  DW  read data, valid while ack is high (meaningful for reads only)
gnt  out  N_REQ  one-hot current owner; 0 when idle
busy  out  1  high whenever state is not IDLE
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid one cycle after mem_en
lock  in  N_REQ  burst lock request (present only with ARB_LOCK_EN)

Behaviour:
- Reset: if reset_L is low at a rising edge, then on that edge state=IDLE, all outputs are 0, last=N_REQ-1, and lock_cnt=0. An in-flight transaction is dropped with no ack.
- FSM states: IDLE -> ACCESS -> WAIT -> ACK -> IDLE.
- IDLE, req==0: stay in IDLE; all outputs 0.
- IDLE, req!=0: choose the winner w by searching last+1, last+2, ... modulo N_REQ. The first set bit wins.
  - On the edge: gnt=onehot(w), mem_en=1, mem_we=we[w], mem_addr=addr[w], mem_wdata=wdata[w], last=w, state=ACCESS.
- ACCESS: lasts one cycle with mem_en high. On the edge: mem_en=0, mem_we=0, state=WAIT. The address and data outputs hold their values.
- WAIT: mem_rdata is valid. On the edge: rdata=mem_rdata (for a write, rdata=0), ack[w]=1, state=ACK.
- ACK: lasts one cycle. ack and rdata are valid. req is not sampled in this cycle. On the edge: ack=0, gnt=0, rdata=0, state=IDLE.
- Requester obligations:
  - Hold we/addr/wdata stable from request until the IDLE edge that grants it.
  - Drop req during the ACK cycle if it has no further work.
  - If req is still high in the next IDLE cycle, that is a new transaction, arbitrated normally.
- Latency: req seen in IDLE cycle c0 gives ack in cycle c0+3. Peak throughput is one transaction per 4 cycles.
- Fairness: a continuously requesting requester waits at most N_REQ-1 transactions.
- req bits that rise during ACCESS/WAIT/ACK are ignored until the next IDLE.
- A requester that drops req while granted does not abort its transaction; ack is still issued.
- Illegal N_REQ values are not supported and need no checks.

Optional Feature:
Macro ARB_LOCK_EN.
- With ARB_LOCK_EN defined: the lock port exists.
  - In IDLE, if the previous winner w still has req[w]=1, lock[w]=1 and lock_cnt<MAX_LOCK-1, then w is granted again and lock_cnt is incremented.
  - Otherwise normal rotation applies and lock_cnt is cleared.
  - lock_cnt resets to 0.
- Without ARB_LOCK_EN: no lock port and no lock_cnt; pure round-robin only.

Test Plan:
- Reset then idle: reset_L=0 for 2 cycles, then req=0 -> gnt=0, ack=0, mem_en=0, busy=0 in every cycle.
- Single read: req=4'b0001, we=0, addr0=8'h12, memory returns 8'hA5 -> mem_en high exactly 1 cycle with mem_addr=8'h12, then ack=4'b0001 3 cycles after request with rdata=8'hA5.
- Single write: req=4'b0100, we[2]=1, addr2=8'h30, wdata2=8'h5C -> one mem_en pulse with mem_we=1, mem_addr=8'h30, mem_wdata=8'h5C; ack=4'b0100; rdata=0.
- Contention: req=4'b1111 held from reset -> grant order 0,1,2,3,0,... with acks every 4 cycles and never two gnt bits set.
- Reset mid-operation: assert reset_L=0 during WAIT -> next cycle all outputs 0, no ack. After release with req=4'b0010, requester 1 is granted first (last was restored to N_REQ-1).
- With ARB_LOCK_EN, MAX_LOCK=4: req=4'b0011, lock=4'b0001 -> requester 0 gets 4 consecutive transactions, then requester 1 gets one, then requester 0 again.
